// File: rtl/key_event_fifo.sv
// Key event queue between a PS/2 decoder and a CPU.
// Edge-detected push, show-ahead pop, and a choice of full-queue policy.
module key_event_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 8,
  parameter int OVERWRITE  = 0
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    ps2_key_pressed,
  input  logic [DATA_WIDTH-1:0]   ps2_out,
  input  logic                    rd_en,
  input  logic                    clear,
  output logic [DATA_WIDTH-1:0]   rd_data,
  output logic                    empty,
  output logic                    full,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]         r_wptr;
  logic [AW-1:0]         r_rptr;
  logic [CW-1:0]         r_cnt;
  logic                  r_ovf;
  logic                  r_key_q;

  logic w_push;
  logic w_pop;
  logic w_full;
  logic w_empty;
  logic w_wr;
  logic w_adv;
  logic w_inc;
  logic w_ovf_set;

  assign w_full  = (r_cnt == CW'(DEPTH));
  assign w_empty = (r_cnt == '0);
  assign w_push  = ps2_key_pressed & ~r_key_q;
  assign w_pop   = rd_en & ~w_empty;

  // A full queue only accepts the new word if a slot frees this cycle
  // or the oldest entry is being evicted.
  assign w_inc     = w_push & (~w_full | w_pop);
  assign w_wr      = ~clear & w_push
                   & (~w_full | w_pop | (OVERWRITE != 0));
  assign w_adv     = w_pop
                   | (w_push & w_full & (OVERWRITE != 0));
  assign w_ovf_set = w_push & w_full & ~w_pop;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_key_q <= 1'b0;
    end else begin
      r_key_q <= ps2_key_pressed;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
      r_ovf  <= 1'b0;
    end else if (clear) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
      r_ovf  <= 1'b0;
    end else begin
      if (w_wr) begin
        r_wptr <= r_wptr + AW'(1);
      end
      if (w_adv) begin
        r_rptr <= r_rptr + AW'(1);
      end
      unique case ({w_inc, w_pop})
        2'b10:   r_cnt <= r_cnt + CW'(1);
        2'b01:   r_cnt <= r_cnt - CW'(1);
        default: r_cnt <= r_cnt;
      endcase
      if (w_ovf_set) begin
        r_ovf <= 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (w_wr) begin
      r_mem[r_wptr] <= ps2_out;
    end
  end

  assign rd_data  = r_mem[r_rptr];
  assign empty    = w_empty;
  assign full     = w_full;
  assign count    = r_cnt;
  assign overflow = r_ovf;

endmodule

// File: tb/tb_key_event_fifo.sv
// Directed bench for key_event_fifo.
// Drop-newest and evict-oldest instances share one stimulus stream.
module tb_key_event_fifo;

  logic        clock = 1'b0;
  logic        reset;
  logic        ps2_key_pressed;
  logic [31:0] ps2_out;
  logic        rd_en;
  logic        clear;

  logic [31:0] rd_data0, rd_data1;
  logic        empty0, empty1;
  logic        full0, full1;
  logic [3:0]  count0, count1;
  logic        ovf0, ovf1;

  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  key_event_fifo #(.DATA_WIDTH(32), .DEPTH(8), .OVERWRITE(0)) u_drop (
    .clock(clock), .reset(reset),
    .ps2_key_pressed(ps2_key_pressed), .ps2_out(ps2_out),
    .rd_en(rd_en), .clear(clear),
    .rd_data(rd_data0), .empty(empty0), .full(full0),
    .count(count0), .overflow(ovf0)
  );

  key_event_fifo #(.DATA_WIDTH(32), .DEPTH(8), .OVERWRITE(1)) u_evict (
    .clock(clock), .reset(reset),
    .ps2_key_pressed(ps2_key_pressed), .ps2_out(ps2_out),
    .rd_en(rd_en), .clear(clear),
    .rd_data(rd_data1), .empty(empty1), .full(full1),
    .count(count1), .overflow(ovf1)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic push(input logic [31:0] c);
    ps2_key_pressed = 1'b1;
    ps2_out = c;
    step();
    ps2_key_pressed = 1'b0;
    step();
  endtask

  task automatic pop();
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    step();
    clear = 1'b0;
  endtask

  initial begin
    reset = 1'b0;
    ps2_key_pressed = 1'b0;
    ps2_out = '0;
    rd_en = 1'b0;
    clear = 1'b0;

    // reset state
    #12;
    chk("rst_empty", 32'(empty0), 32'd1);
    chk("rst_full", 32'(full0), 32'd0);
    chk("rst_count", 32'(count0), 32'd0);
    chk("rst_ovf", 32'(ovf0), 32'd0);
    chk("rst_empty_ev", 32'(empty1), 32'd1);
    step();
    reset = 1'b1;
    step();

    // long strobe gives exactly one push, visible after one edge
    ps2_key_pressed = 1'b1;
    ps2_out = 32'd5;
    step();
    chk("strobe_cnt1", 32'(count0), 32'd1);
    chk("strobe_data", rd_data0, 32'd5);
    chk("strobe_empty", 32'(empty0), 32'd0);
    step();
    step();
    chk("strobe_cnt3", 32'(count0), 32'd1);
    chk("strobe_cnt3_ev", 32'(count1), 32'd1);
    ps2_key_pressed = 1'b0;
    step();
    do_clear();
    chk("clr_cnt", 32'(count0), 32'd0);

    // nine pushes into an eight-deep queue
    for (int i = 1; i <= 9; i++) push(32'(i));
    chk("ovr_full", 32'(full0), 32'd1);
    chk("ovr_ovf", 32'(ovf0), 32'd1);
    chk("ovr_cnt", 32'(count0), 32'd8);
    chk("ev_cnt", 32'(count1), 32'd8);
    chk("ev_ovf", 32'(ovf1), 32'd1);
    for (int i = 1; i <= 8; i++) begin
      chk($sformatf("drop_pop%0d", i), rd_data0, 32'(i));
      chk($sformatf("ev_pop%0d", i), rd_data1, 32'(i + 1));
      pop();
    end
    chk("drain_empty", 32'(empty0), 32'd1);
    chk("drain_empty_ev", 32'(empty1), 32'd1);
    chk("drain_ovf_sticky", 32'(ovf0), 32'd1);
    do_clear();
    chk("clr_ovf", 32'(ovf0), 32'd0);
    chk("clr_ovf_ev", 32'(ovf1), 32'd0);

    // push and pop together on a full queue
    for (int i = 1; i <= 8; i++) push(32'(i));
    chk("pp_full_pre", 32'(count0), 32'd8);
    ps2_key_pressed = 1'b1;
    ps2_out = 32'h0B;
    rd_en = 1'b1;
    step();
    ps2_key_pressed = 1'b0;
    rd_en = 1'b0;
    chk("pp_full_cnt", 32'(count0), 32'd8);
    chk("pp_full_ovf", 32'(ovf0), 32'd0);
    chk("pp_full_ovf_ev", 32'(ovf1), 32'd0);
    step();
    for (int i = 2; i <= 8; i++) begin
      chk($sformatf("pp_pop%0d", i), rd_data0, 32'(i));
      pop();
    end
    chk("pp_last", rd_data0, 32'h0B);
    chk("pp_last_ev", rd_data1, 32'h0B);
    pop();
    chk("pp_empty", 32'(empty0), 32'd1);

    // pop on empty is ignored; push+pop on empty keeps the push
    rd_en = 1'b1;
    step();
    chk("epop_cnt", 32'(count0), 32'd0);
    chk("epop_ovf", 32'(ovf0), 32'd0);
    ps2_key_pressed = 1'b1;
    ps2_out = 32'h77;
    step();
    rd_en = 1'b0;
    ps2_key_pressed = 1'b0;
    chk("epp_cnt", 32'(count0), 32'd1);
    chk("epp_data", rd_data0, 32'h77);
    step();
    do_clear();

    // asynchronous reset mid-cycle
    for (int i = 0; i < 3; i++) push(32'(i + 20));
    chk("ar_pre", 32'(count0), 32'd3);
    #2;
    reset = 1'b0;
    #1;
    chk("ar_empty", 32'(empty0), 32'd1);
    chk("ar_cnt", 32'(count0), 32'd0);
    chk("ar_cnt_ev", 32'(count1), 32'd0);
    step();
    reset = 1'b1;
    step();

    // clear with five entries and sticky overflow
    for (int i = 1; i <= 9; i++) push(32'(i));
    for (int i = 0; i < 3; i++) pop();
    chk("c5_cnt", 32'(count0), 32'd5);
    chk("c5_ovf", 32'(ovf0), 32'd1);
    chk("c5_data_ev", rd_data1, 32'd5);
    clear = 1'b1;
    ps2_key_pressed = 1'b1;
    ps2_out = 32'h99;
    step();
    clear = 1'b0;
    chk("c5_clr_cnt", 32'(count0), 32'd0);
    chk("c5_clr_ovf", 32'(ovf0), 32'd0);
    chk("c5_clr_ovf_ev", 32'(ovf1), 32'd0);
    step();
    chk("c5_held_nopush", 32'(count0), 32'd0);
    ps2_key_pressed = 1'b0;
    step();

    // strobe already high at reset release pushes once
    reset = 1'b0;
    ps2_key_pressed = 1'b1;
    ps2_out = 32'h3C;
    #3;
    reset = 1'b1;
    step();
    chk("rel_cnt", 32'(count0), 32'd1);
    chk("rel_data", rd_data0, 32'h3C);
    step();
    chk("rel_hold", 32'(count0), 32'd1);
    ps2_key_pressed = 1'b0;
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/key_event_fifo.md
KEY_EVENT_FIFO -- requirements
Module: key_event_fifo

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, meaning width of one key event word.
REQ-002 The block SHALL have parameter DEPTH, default 8, meaning number of entries; legal values are powers of two, 2..256.
REQ-003 The block SHALL have parameter OVERWRITE, default 0, meaning full-queue policy: 0 drops the newest event, 1 evicts the oldest event.
REQ-004 The block SHALL have port clock, input, 1, single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port reset, input, 1, asynchronous active-low reset (0 = reset asserted).
REQ-006 The block SHALL have port ps2_key_pressed, input, 1, key strobe from the PS/2 decoder; may stay high for several cycles.
REQ-007 The block SHALL have port ps2_out, input, DATA_WIDTH, key code, valid while ps2_key_pressed is high.
REQ-008 The block SHALL have port rd_en, input, 1, processor pop request.
REQ-009 The block SHALL have port clear, input, 1, synchronous flush.
REQ-010 The block SHALL have port rd_data, output, DATA_WIDTH, head entry (show-ahead).
REQ-011 The block SHALL have port empty, output, 1, queue holds zero entries.
REQ-012 The block SHALL have port full, output, 1, queue holds DEPTH entries.
REQ-013 The block SHALL have port count, output, log2(DEPTH)+1, current occupancy.
REQ-014 The block SHALL have port overflow, output, 1, sticky flag: an event was dropped or evicted.

Function
REQ-015 The block SHALL register ps2_key_pressed each cycle and generate push only on a rising edge (current 1, previous 0); one push per strobe, regardless of strobe length.
REQ-016 On push, the block SHALL write ps2_out, sampled at that same clock edge, to the tail entry.
REQ-017 Latency SHALL be one edge: the entry is visible on rd_data, and empty deasserts, immediately after the edge that detects the push.
REQ-018 rd_data SHALL equal the head entry whenever empty=0; its value when empty=1 is don't-care.
REQ-019 A pop (rd_en=1 and empty=0) SHALL advance the head by one at the clock edge.
REQ-020 rd_en while empty=1 SHALL be ignored: no pointer change, no flag change.
REQ-021 Read and write pointers SHALL be log2(DEPTH) bits wide and wrap from DEPTH-1 to 0.
REQ-022 count SHALL equal the number of pushes minus the number of pops, held within 0..DEPTH.
REQ-023 full SHALL equal (count==DEPTH) and empty SHALL equal (count==0); both are combinational from count.
REQ-024 When push and pop occur together with 0<count<DEPTH, both SHALL take effect and count SHALL be unchanged.
REQ-025 When push and pop occur together with count==DEPTH, both SHALL take effect, count SHALL stay DEPTH, and overflow SHALL not be set.
REQ-026 When push and pop occur together with count==0, the push SHALL take effect, the pop SHALL be ignored, and count SHALL become 1.
REQ-027 On a push with count==DEPTH and no pop, if OVERWRITE=0, the event SHALL be discarded and the queue unchanged.
REQ-028 On a push with count==DEPTH and no pop, if OVERWRITE=1, the head SHALL advance, the new event SHALL be written at the tail, and count SHALL stay DEPTH.
REQ-029 In both cases of REQ-027 and REQ-028, overflow SHALL be set to 1 and remain set until clear or reset.
REQ-030 clear=1 SHALL, at the clock edge, zero both pointers, count, and overflow; a same-cycle push or pop SHALL be ignored; the edge-detect register still updates.

Reset
REQ-031 While reset=0, asynchronously: pointers=0, count=0, overflow=0, and the edge-detect register=0; therefore empty=1 and full=0.
REQ-032 Storage contents SHALL not require reset.
REQ-033 A key strobe already high when reset deasserts SHALL produce one push on the first edge after deassertion.
REQ-034 Reset asserted mid-operation SHALL discard all queued events, with outputs reaching reset values without waiting for a clock edge.

Verification
REQ-035 Reset, then hold ps2_key_pressed high for 3 cycles with ps2_out=5 -> exactly one entry; count=1; rd_data=5.
REQ-036 DEPTH=8, OVERWRITE=0: push codes 1..9 with no reads -> full=1, overflow=1; 8 pops return 1..8; then empty=1.
REQ-037 DEPTH=8, OVERWRITE=1: push codes 1..9 -> count=8, overflow=1; pops return 2..9.
REQ-038 With count=8, pulse push (code 0xB) and rd_en together -> count=8, overflow=0; the last pop after draining returns 0xB.
REQ-039 With empty=1, assert rd_en alone -> count stays 0; then assert push and rd_en together -> count=1.
REQ-040 With count=3, assert reset low between clock edges -> empty=1 and count=0 before the next edge; clear with count=5 -> count=0 and overflow=0 after one edge.
